test_supervisor: RTL

TEST_SUPERVISOR -- requirements
Module: test_supervisor

---
 rtl/test_supervisor_pkg.sv | 30 +++
 rtl/tsv_channel_tracker.sv | 50 +++++
 rtl/test_supervisor.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/test_supervisor_pkg.sv
// Shared types for the test supervisor: FSM states, failure reasons and field widths.
package test_supervisor_pkg;

  localparam int unsigned ReasonW  = 2;
  localparam int unsigned ChanIdxW = 5;

  typedef enum logic [1:0] {
    StHold,
    StRun,
    StPass,
    StFail
  } state_e;

  typedef enum logic [ReasonW-1:0] {
    ReasonNone     = 2'd0,
    ReasonChannel  = 2'd1,
    ReasonTimeout  = 2'd2,
    ReasonWatchdog = 2'd3
  } fail_reason_e;

  function automatic logic [ChanIdxW-1:0] lowest_index(input logic [31:0] vec);
    logic [ChanIdxW-1:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = ChanIdxW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/tsv_channel_tracker.sv
// One supervised channel: sticky success flag, plus an idle counter when
// TEST_SUPERVISOR_WATCHDOG_EN is defined.
module tsv_channel_tracker
`ifdef TEST_SUPERVISOR_WATCHDOG_EN
#(
  parameter int unsigned WDOG_LIMIT = 1024
)
`endif
(
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic success,
`ifdef TEST_SUPERVISOR_WATCHDOG_EN
  input  logic heartbeat,
  output logic wdog_hit,
`endif
  output logic flag
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flag <= 1'b0;
    end else if (run && success) begin
      flag <= 1'b1;
    end
  end

`ifdef TEST_SUPERVISOR_WATCHDOG_EN
  localparam int unsigned IdleW = $clog2(WDOG_LIMIT + 1);

  logic [IdleW-1:0] idle_q;

  // A channel that has already succeeded can no longer starve.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idle_q <= '0;
    end else if (run) begin
      if (heartbeat || success || flag) begin
        idle_q <= '0;
      end else if (idle_q != IdleW'(WDOG_LIMIT)) begin
        idle_q <= idle_q + IdleW'(1);
      end
    end
  end

  assign wdog_hit = (idle_q == IdleW'(WDOG_LIMIT));
`endif

endmodule

// File: rtl/test_supervisor.sv
// Test-harness supervisor: holds the harness in reset, then runs until pass, channel
// failure or timeout. Define TEST_SUPERVISOR_WATCHDOG_EN to add per-channel watchdogs.
module test_supervisor
  import test_supervisor_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CYCLE_W    = 64,
  parameter int unsigned RESET_HOLD = 16,
  parameter bit          PASS_ALL   = 1'b1
`ifdef TEST_SUPERVISOR_WATCHDOG_EN
  ,
  parameter int unsigned WDOG_LIMIT = 1024
`endif
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CYCLE_W-1:0]  max_cycles,
  input  logic [CYCLE_W-1:0]  dump_start,
  input  logic [NUM_CH-1:0]   ch_success,
  input  logic [NUM_CH-1:0]   ch_failure,
`ifdef TEST_SUPERVISOR_WATCHDOG_EN
  input  logic [NUM_CH-1:0]   ch_heartbeat,
`endif
  output logic                dut_reset,
  output logic                dump_en,
  output logic [CYCLE_W-1:0]  cycle_count,
  output logic                done,
  output logic                pass,
  output logic                fail,
  output logic [ReasonW-1:0]  fail_reason,
  output logic [ChanIdxW-1:0] fail_channel
);

  localparam int unsigned     HoldW    = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(RESET_HOLD - 1);

  state_e             state_q;
  logic [HoldW-1:0]   hold_q;
  logic [NUM_CH-1:0]  flags;
  logic [NUM_CH-1:0]  reached;
  logic               run;
  logic               pass_met;
  logic               chan_fail;
  logic               wdog_fail;
  logic               timeout;
  logic               leave_run;
  logic [CYCLE_W-1:0] cycle_d;
`ifdef TEST_SUPERVISOR_WATCHDOG_EN
  logic [NUM_CH-1:0]  wdog_hit;
`endif

  assign run = (state_q == StRun);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tsv_channel_tracker
`ifdef TEST_SUPERVISOR_WATCHDOG_EN
    #(
      .WDOG_LIMIT(WDOG_LIMIT)
    )
`endif
    u_tracker (
      .clock    (clock),
      .reset    (reset),
      .run      (run),
      .success  (ch_success[i]),
`ifdef TEST_SUPERVISOR_WATCHDOG_EN
      .heartbeat(ch_heartbeat[i]),
      .wdog_hit (wdog_hit[i]),
`endif
      .flag     (flags[i])
    );
  end

`ifdef TEST_SUPERVISOR_WATCHDOG_EN
  assign wdog_fail = |wdog_hit;
`else
  assign wdog_fail = 1'b0;
`endif

  // Pass is judged on the flags plus this cycle's successes.
  assign reached   = flags | ch_success;
  assign pass_met  = PASS_ALL ? (&reached) : (|reached);
  assign chan_fail = |ch_failure;
  assign timeout   = (max_cycles != '0) && (cycle_count >= max_cycles);
  assign leave_run = chan_fail || wdog_fail || timeout || pass_met;

  // The counter stops at the limit on a timeout, so it reports exactly max_cycles.
  always_comb begin
    cycle_d = cycle_count;
    if (!timeout && (cycle_count != '1)) begin
      cycle_d = cycle_count + CYCLE_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StHold;
      hold_q       <= '0;
      cycle_count  <= '0;
      dut_reset    <= 1'b1;
      dump_en      <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      fail_reason  <= ReasonNone;
      fail_channel <= '0;
    end else begin
      unique case (state_q)
        StHold: begin
          if (hold_q == HoldLast) begin
            state_q   <= StRun;
            dut_reset <= 1'b0;
            dump_en   <= (dump_start == '0);
          end else begin
            hold_q <= hold_q + HoldW'(1);
          end
        end
        StRun: begin
          cycle_count <= cycle_d;
          dump_en     <= !leave_run && (cycle_d >= dump_start);
          done        <= leave_run;
          if (chan_fail) begin
            state_q      <= StFail;
            fail         <= 1'b1;
            fail_reason  <= ReasonChannel;
            fail_channel <= lowest_index(32'(ch_failure));
`ifdef TEST_SUPERVISOR_WATCHDOG_EN
          end else if (wdog_fail) begin
            state_q      <= StFail;
            fail         <= 1'b1;
            fail_reason  <= ReasonWatchdog;
            fail_channel <= lowest_index(32'(wdog_hit));
`endif
          end else if (timeout) begin
            state_q      <= StFail;
            fail         <= 1'b1;
            fail_reason  <= ReasonTimeout;
            fail_channel <= '0;
          end else if (pass_met) begin
            state_q <= StPass;
            pass    <= 1'b1;
          end
        end
        StPass, StFail: begin
        end
        default: begin
          state_q <= StHold;
        end
      endcase
    end
  end

endmodule
